// File: rtl/q_stream_pkg.sv
// Shared types and constants for the sum-stream differencer slice.
package q_stream_pkg;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam int Q_IN_W  = 32;
  localparam int Q_OUT_W = 16;

  // Signed range of a recovered sample.
  localparam logic signed [Q_OUT_W-1:0] SMIN = 16'sh8000;
  localparam logic signed [Q_OUT_W-1:0] SMAX = 16'sh7FFF;

  // Min/max trackers start inverted so the first emitted sample sets both.
  localparam logic signed [Q_OUT_W-1:0] MIN_RST = SMAX;
  localparam logic signed [Q_OUT_W-1:0] MAX_RST = SMIN;

endpackage

// File: rtl/sum_stream_differencer_if.sv
// Valid/ready stream carrying one signed word per beat.
interface sum_stream_differencer_if #(
  parameter int W = 32
);
  logic                valid;
  logic                ready;
  logic signed [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register with load, drain and flush.
module stream_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] load_data,
  input  logic                     drain,
  output logic                     valid,
  output logic signed [DATA_W-1:0] data
);

  // Load wins over drain so accept and drain in one cycle keep full throughput.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sum_stream_differencer.sv
// Recovers samples from a stream of running sums: d[n] = sum[n] - sum[n-1].
// Differences that do not fit the output width raise a sticky error and halt.
module sum_stream_differencer
  import q_stream_pkg::*;
#(
  parameter int IN_W  = Q_IN_W,
  parameter int OUT_W = Q_OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  sum_stream_differencer_if.slave  s,
  sum_stream_differencer_if.master m,
  output logic                    range_err,
  output logic                    halted,
  output logic signed [OUT_W-1:0] min_val,
  output logic signed [OUT_W-1:0] max_val,
  output logic [31:0]             sample_count
);

  state_t                  state;
  logic signed [IN_W-1:0]  prev;
  logic signed [IN_W:0]    diff_p0;
  logic signed [OUT_W-1:0] samp_p0;
  logic                    fits_p0;
  logic                    accept;
  logic                    load;

  // A value fits OUT_W signed bits when every bit from OUT_W-1 upward matches the sign.
  function automatic logic fits_out(input logic signed [IN_W:0] d);
    logic [IN_W-OUT_W+1:0] top;
    top = d[IN_W:OUT_W-1];
    return (&top) | ~(|top);
  endfunction

  // Stage p0: full-width difference, range check and handshake.
  assign diff_p0 = {s.data[IN_W-1], s.data} - {prev[IN_W-1], prev};
  assign samp_p0 = diff_p0[OUT_W-1:0];
  assign fits_p0 = fits_out(diff_p0);
  assign s.ready = (state == RUN) && !clear && (!m.valid || m.ready);
  assign accept  = s.valid && s.ready;
  assign load    = accept && fits_p0;
  assign halted  = (state == HALT);

  // Stage p1: registered recovered sample.
  stream_out_reg #(.DATA_W(OUT_W)) u_out (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .load      (load),
    .load_data (samp_p0),
    .drain     (m.ready),
    .valid     (m.valid),
    .data      (m.data)
  );

  // FSM, previous sum, sticky error and running statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      prev         <= '0;
      range_err    <= 1'b0;
      min_val      <= OUT_W'(MIN_RST);
      max_val      <= OUT_W'(MAX_RST);
      sample_count <= '0;
    end else if (clear) begin
      state        <= RUN;
      prev         <= '0;
      range_err    <= 1'b0;
      min_val      <= OUT_W'(MIN_RST);
      max_val      <= OUT_W'(MAX_RST);
      sample_count <= '0;
    end else if (accept) begin
      if (sample_count != 32'hFFFF_FFFF) begin
        sample_count <= sample_count + 32'd1;
      end
      if (fits_p0) begin
        prev <= s.data;
        if (samp_p0 < min_val) min_val <= samp_p0;
        if (samp_p0 > max_val) max_val <= samp_p0;
      end else begin
        range_err <= 1'b1;
        state     <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_sum_stream_differencer.sv
// Directed bench for sum_stream_differencer.
module tb_sum_stream_differencer;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic range_err;
  logic halted;
  logic signed [15:0] min_val;
  logic signed [15:0] max_val;
  logic [31:0] sample_count;

  int total = 0;
  int bad = 0;

  sum_stream_differencer_if #(.W(32)) s_if ();
  sum_stream_differencer_if #(.W(16)) m_if ();

  sum_stream_differencer dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .s            (s_if),
    .m            (m_if),
    .range_err    (range_err),
    .halted       (halted),
    .min_val      (min_val),
    .max_val      (max_val),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    s_if.valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0;
    s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b1;
    step(); step();
    total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_if.valid); end
    total++; if (m_if.data !== 16'sd0) begin bad++; $display("FAIL reset_m_data got=%0d exp=0", m_if.data); end
    total++; if (min_val !== 16'sh7FFF) begin bad++; $display("FAIL reset_min got=%h exp=7fff", min_val); end
    total++; if (max_val !== 16'sh8000) begin bad++; $display("FAIL reset_max got=%h exp=8000", max_val); end
    total++; if ({range_err, halted} !== 2'b00) begin bad++; $display("FAIL reset_err_halt got=%b exp=00", {range_err, halted}); end
    total++; if (sample_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", sample_count); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic signed [31:0] sums [3] = '{32'sd5, 32'sd12, 32'sd2};
    logic signed [15:0] exps [3] = '{16'sd5, 16'sd7, -16'sd10};
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.data = sums[i];
      step();
      total++; if (m_if.valid !== 1'b1 || m_if.data !== exps[i]) begin bad++; $display("FAIL basic_out%0d got=%b/%0d exp=1/%0d", i, m_if.valid, m_if.data, exps[i]); end
    end
    s_if.valid = 1'b0;
    step();
    total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", m_if.valid); end
    total++; if (min_val !== -16'sd10 || max_val !== 16'sd7) begin bad++; $display("FAIL basic_minmax got=%0d/%0d exp=-10/7", min_val, max_val); end
    total++; if (sample_count !== 32'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", sample_count); end
  endtask

  task automatic test_overflow();
    do_clear();
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    s_if.data = 32'sd0;
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd0) begin bad++; $display("FAIL ovf_out0 got=%b/%0d exp=1/0", m_if.valid, m_if.data); end
    s_if.data = 32'sd32767;
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd32767) begin bad++; $display("FAIL ovf_out1 got=%b/%0d exp=1/32767", m_if.valid, m_if.data); end
    s_if.data = 32'sd65536;
    step();
    total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL ovf_no_out got=%b exp=0", m_if.valid); end
    total++; if ({range_err, halted} !== 2'b11) begin bad++; $display("FAIL ovf_err_halt got=%b exp=11", {range_err, halted}); end
    total++; if (sample_count !== 32'd3) begin bad++; $display("FAIL ovf_count got=%0d exp=3", sample_count); end
    total++; if (s_if.ready !== 1'b0) begin bad++; $display("FAIL ovf_s_ready got=%b exp=0", s_if.ready); end
    total++; if (max_val !== 16'sd32767) begin bad++; $display("FAIL ovf_max got=%0d exp=32767", max_val); end
    s_if.valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_clear();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.data = 32'sd10;
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd10) begin bad++; $display("FAIL bp_first got=%b/%0d exp=1/10", m_if.valid, m_if.data); end
    s_if.data = 32'sd30;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (s_if.ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready%0d got=%b exp=0", i, s_if.ready); end
      step();
      total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd10 || sample_count !== 32'd1) begin bad++; $display("FAIL bp_hold%0d got=%b/%0d/%0d exp=1/10/1", i, m_if.valid, m_if.data, sample_count); end
    end
    m_if.ready = 1'b1;
    #1;
    total++; if (s_if.ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", s_if.ready); end
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd20) begin bad++; $display("FAIL bp_out1 got=%b/%0d exp=1/20", m_if.valid, m_if.data); end
    s_if.data = 32'sd31;
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd1) begin bad++; $display("FAIL bp_out2 got=%b/%0d exp=1/1", m_if.valid, m_if.data); end
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd0) begin bad++; $display("FAIL bp_out3 got=%b/%0d exp=1/0", m_if.valid, m_if.data); end
    s_if.valid = 1'b0;
    step();
    total++; if (m_if.valid !== 1'b0 || sample_count !== 32'd4) begin bad++; $display("FAIL bp_end got=%b/%0d exp=0/4", m_if.valid, sample_count); end
  endtask

  task automatic test_neg_bound();
    do_clear();
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    s_if.data = -32'sd32768;
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== -16'sd32768 || range_err !== 1'b0) begin bad++; $display("FAIL neg_out got=%b/%0d/%b exp=1/-32768/0", m_if.valid, m_if.data, range_err); end
    total++; if (min_val !== -16'sd32768 || max_val !== -16'sd32768) begin bad++; $display("FAIL neg_minmax got=%0d/%0d exp=-32768/-32768", min_val, max_val); end
    s_if.data = 32'sh7FFF_FFFF;
    step();
    total++; if ({range_err, halted, m_if.valid} !== 3'b110) begin bad++; $display("FAIL neg_big got=%b exp=110", {range_err, halted, m_if.valid}); end
    total++; if (min_val !== -16'sd32768 || sample_count !== 32'd2) begin bad++; $display("FAIL neg_keep got=%0d/%0d exp=-32768/2", min_val, sample_count); end
    s_if.valid = 1'b0;
  endtask

  task automatic test_halt_clear();
    do_clear();
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    s_if.data = 32'sd7;
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd7) begin bad++; $display("FAIL halt_pending got=%b/%0d exp=1/7", m_if.valid, m_if.data); end
    // Low 16 bits of the difference are zero; only the wide check catches it.
    s_if.data = 32'sh8000_0007;
    step();
    total++; if ({halted, m_if.valid} !== 2'b10) begin bad++; $display("FAIL halt_drain got=%b exp=10", {halted, m_if.valid}); end
    s_if.data = 32'sd8;
    for (int i = 0; i < 3; i++) begin
      total++; if (s_if.ready !== 1'b0) begin bad++; $display("FAIL halt_s_ready%0d got=%b exp=0", i, s_if.ready); end
      step();
    end
    total++; if (sample_count !== 32'd2 || m_if.valid !== 1'b0) begin bad++; $display("FAIL halt_no_consume got=%0d/%b exp=2/0", sample_count, m_if.valid); end
    do_clear();
    total++; if (min_val !== 16'sh7FFF || max_val !== 16'sh8000 || sample_count !== 32'd0) begin bad++; $display("FAIL clr_stats got=%h/%h/%0d exp=7fff/8000/0", min_val, max_val, sample_count); end
    total++; if ({range_err, halted} !== 2'b00) begin bad++; $display("FAIL clr_err got=%b exp=00", {range_err, halted}); end
    s_if.valid = 1'b1;
    s_if.data = 32'sd3;
    step();
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd3) begin bad++; $display("FAIL clr_prev got=%b/%0d exp=1/3", m_if.valid, m_if.data); end
    // Clear with a pending output and a valid input: output dropped, nothing accepted.
    m_if.ready = 1'b0;
    s_if.data = 32'sd100;
    clear = 1'b1;
    #1;
    total++; if (s_if.ready !== 1'b0) begin bad++; $display("FAIL clr_s_ready got=%b exp=0", s_if.ready); end
    step();
    clear = 1'b0;
    total++; if (m_if.valid !== 1'b0 || sample_count !== 32'd0) begin bad++; $display("FAIL clr_flush got=%b/%0d exp=0/0", m_if.valid, sample_count); end
    s_if.valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.data = 32'sd4;
    step();
    s_if.valid = 1'b0;
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd4) begin bad++; $display("FAIL ar_pending got=%b/%0d exp=1/4", m_if.valid, m_if.data); end
    #2 reset = 1'b1;
    #1;
    total++; if (m_if.valid !== 1'b0 || m_if.data !== 16'sd0 || sample_count !== 32'd0) begin bad++; $display("FAIL ar_immediate got=%b/%0d/%0d exp=0/0/0", m_if.valid, m_if.data, sample_count); end
    total++; if (min_val !== 16'sh7FFF || max_val !== 16'sh8000) begin bad++; $display("FAIL ar_minmax got=%h/%h exp=7fff/8000", min_val, max_val); end
    step();
    reset = 1'b0;
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    s_if.data = 32'sd9;
    step();
    s_if.valid = 1'b0;
    total++; if (m_if.valid !== 1'b1 || m_if.data !== 16'sd9) begin bad++; $display("FAIL ar_restart got=%b/%0d exp=1/9", m_if.valid, m_if.data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_neg_bound();
    test_halt_clear();
    test_async_reset();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
